// File: rtl/cooling_fan_sequencer_if.sv
// rtl/cooling_fan_sequencer_if.sv - sensor inputs and fan drive outputs of the cooling fan sequencer
//
// master: the environment side. It drives tick, calorie, temperature, pressure,
//         air_pressure and tach, and observes the fan outputs.
// slave : the sequencer side. It consumes the sensor inputs and drives fan,
//         fan_pwm, duty, fan_angle, state and stall.
interface cooling_fan_sequencer_if;
    logic       tick;
    logic [2:0] calorie;
    logic [2:0] temperature;
    logic       pressure;
    logic       air_pressure;
    logic       tach;
    logic       fan;
    logic       fan_pwm;
    logic [2:0] duty;
    logic [2:0] fan_angle;
    logic [2:0] state;
    logic       stall;

    modport master (
        output tick, calorie, temperature, pressure, air_pressure, tach,
        input  fan, fan_pwm, duty, fan_angle, state, stall
    );

    modport slave (
        input  tick, calorie, temperature, pressure, air_pressure, tach,
        output fan, fan_pwm, duty, fan_angle, state, stall
    );
endinterface

// File: rtl/cooling_fan_sequencer.sv
// rtl/cooling_fan_sequencer.sv - tick-driven cooling fan sequencer with louvre sweep and PWM drive
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - cooling_fan_sequencer_if.slave:
//          in : tick, calorie[2:0], temperature[2:0], pressure, air_pressure, tach
//          out: fan, fan_pwm, duty[2:0], fan_angle[2:0], state[2:0], stall
// Optional feature: define FAN_STALL_DETECT_EN to enable tach-based stall detection.
module cooling_fan_sequencer #(
    parameter int CAL_TH       = 1,
    parameter int TEMP_TH      = 1,
    parameter int SPINUP_TICKS = 4,
    parameter int COOL_TICKS   = 8,
    parameter int SWEEP_DIV    = 2,
    parameter int ANGLE_MAX    = 5,
    parameter int STALL_TICKS  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    cooling_fan_sequencer_if.slave  bus
);
    localparam int CW = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SPINUP   = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_SWEEP    = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;
    localparam logic [2:0] S_STALL    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    angle_q, angle_d;
    logic [2:0]    duty_q, duty_d;
    logic          fan_q, fan_d;
    logic          stall_q, stall_d;
    logic [2:0]    pwm_cnt_q;
    logic          hot, active, stall_hit;

    assign hot    = (bus.calorie > 3'(CAL_TH)) && (bus.temperature > 3'(TEMP_TH));
    assign active = (state_q == S_RUN) || (state_q == S_SWEEP) || (state_q == S_HOLD);

`ifdef FAN_STALL_DETECT_EN
    logic          tach_q;
    logic          tach_rise;
    logic [CW-1:0] tach_cnt_q;

    assign tach_rise = bus.tach & ~tach_q;
    // Stall fires on the active tick that would complete STALL_TICKS edge-free ticks.
    assign stall_hit = active & ~tach_rise & (tach_cnt_q == CW'(STALL_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tach_q     <= 1'b0;
            tach_cnt_q <= '0;
        end else begin
            tach_q <= bus.tach;
            if (tach_rise || (bus.tick && (state_d != state_q)))
                tach_cnt_q <= '0;
            else if (bus.tick && active)
                tach_cnt_q <= tach_cnt_q + CW'(1);
        end
    end
`else
    logic unused_tach;
    assign unused_tach = bus.tach;
    assign stall_hit   = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            div_q      <= '0;
            angle_q    <= '0;
            duty_q     <= '0;
            fan_q      <= 1'b0;
            stall_q    <= 1'b0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            angle_q    <= angle_d;
            duty_q     <= duty_d;
            fan_q      <= fan_d;
            stall_q    <= stall_d;
            pwm_cnt_q  <= pwm_cnt_q + 3'd1;
        end
    end

    // Next state plus the spin-up/cool-down counter and louvre sweep position.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        div_d      = div_q;
        angle_d    = angle_q;
        if (state_q == 3'd7) begin
            state_d = S_IDLE;
        end else if (bus.tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hot) begin
                        state_d    = S_SPINUP;
                        tick_cnt_d = '0;
                    end
                end
                S_SPINUP: begin
                    if (tick_cnt_q == CW'(SPINUP_TICKS - 1)) begin
                        state_d    = S_RUN;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                S_RUN, S_SWEEP, S_HOLD: begin
                    if (stall_hit) begin
                        state_d = S_STALL;
                    end else if (!hot) begin
                        state_d    = S_COOLDOWN;
                        tick_cnt_d = '0;
                    end else if (bus.pressure) begin
                        state_d = S_RUN;
                    end else if (bus.air_pressure) begin
                        state_d = S_SWEEP;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_COOLDOWN: begin
                    if (hot) begin
                        state_d    = S_RUN;
                        tick_cnt_d = '0;
                    end else if (tick_cnt_q == CW'(COOL_TICKS - 1)) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                default: ;  // STALL is held until reset
            endcase

            // Every tick that lands in SWEEP advances the divider; HOLD leaves it frozen.
            if (state_d == S_SWEEP) begin
                if (div_q == CW'(SWEEP_DIV - 1)) begin
                    div_d   = '0;
                    angle_d = (angle_q == 3'(ANGLE_MAX)) ? 3'd0 : angle_q + 3'd1;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end else if ((state_d == S_RUN) || (state_d == S_COOLDOWN)) begin
                div_d   = '0;
                angle_d = '0;
            end
        end
    end

    // Registered outputs follow the upcoming state; duty tracks temperature while running.
    always_comb begin
        fan_d   = 1'b0;
        duty_d  = 3'd0;
        stall_d = stall_q | (state_d == S_STALL);
        case (state_d)
            S_SPINUP: begin
                fan_d  = 1'b1;
                duty_d = 3'd7;
            end
            S_RUN, S_SWEEP, S_HOLD: begin
                fan_d = 1'b1;
                if (bus.temperature >= 3'd6)
                    duty_d = 3'd7;
                else if (bus.temperature >= 3'd4)
                    duty_d = 3'd5;
                else
                    duty_d = 3'd3;
            end
            S_COOLDOWN: begin
                fan_d  = 1'b1;
                duty_d = 3'd2;
            end
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.fan       = fan_q;
    assign bus.duty      = duty_q;
    assign bus.fan_angle = angle_q;
    assign bus.stall     = stall_q;
    assign bus.fan_pwm   = fan_q && (pwm_cnt_q < duty_q);
endmodule

// File: doc/cooling_fan_sequencer.md
COOLING_FAN_SEQUENCER -- requirements
Module: cooling_fan_sequencer

Interface
REQ-001 Parameters SHALL be: CAL_TH, 1, calorie threshold; TEMP_TH, 1, temperature threshold; SPINUP_TICKS, 4, ticks at full kick; COOL_TICKS, 8, consecutive cool ticks before shutdown; SWEEP_DIV, 2, ticks per angle step; ANGLE_MAX, 5, last sweep angle; STALL_TICKS, 6, tach timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-cycle sample strobe; FSM decisions occur only when high.
REQ-005 calorie  input  3  rider effort level.
REQ-006 temperature  input  3  body temperature level.
REQ-007 pressure  input  1  grip pressure; 1 = rider gripping.
REQ-008 air_pressure  input  1  airflow present.
REQ-009 tach  input  1  fan tachometer pulse, synchronous to clk.
REQ-010 fan  output  1  fan enable.
REQ-011 fan_pwm  output  1  PWM drive.
REQ-012 duty  output  3  current duty code, 0..7.
REQ-013 fan_angle  output  3  louvre angle, 0..ANGLE_MAX.
REQ-014 state  output  3  FSM state code.
REQ-015 stall  output  1  sticky stall fault.

Function
REQ-016 hot SHALL be (calorie > CAL_TH) && (temperature > TEMP_TH), unsigned 3-bit compares.
REQ-017 States SHALL be IDLE=0, SPINUP=1, RUN=2, SWEEP=3, HOLD=4, COOLDOWN=5, STALL=6; codes 7 SHALL go to IDLE on next cycle.
REQ-018 Transitions SHALL occur only on cycles with tick=1; outputs registered, update one clk after the deciding tick.
REQ-019 IDLE: hot -> SPINUP, tick counter cleared; else stay.
REQ-020 SPINUP: after SPINUP_TICKS ticks -> RUN regardless of inputs.
REQ-021 RUN/SWEEP/HOLD priority: !hot -> COOLDOWN; else pressure=1 -> RUN; else air_pressure=1 -> SWEEP; else (from SWEEP/HOLD) HOLD; RUN with pressure=0 and air_pressure=0 -> HOLD.
REQ-022 SWEEP: angle divider counts ticks; every SWEEP_DIV-th tick fan_angle increments, ANGLE_MAX wraps to 0.
REQ-023 HOLD: fan_angle and divider frozen; re-entering SWEEP resumes from frozen values.
REQ-024 Entering RUN or COOLDOWN SHALL clear fan_angle and divider.
REQ-025 COOLDOWN: hot -> RUN (no spin-up); COOL_TICKS consecutive not-hot ticks -> IDLE; counter clears on any hot tick.
REQ-026 duty: IDLE 0; SPINUP 7; RUN/SWEEP/HOLD 7 if temperature>=6, 5 if >=4, else 3; COOLDOWN 2; STALL 0.
REQ-027 fan SHALL be 1 in SPINUP, RUN, SWEEP, HOLD, COOLDOWN; 0 in IDLE, STALL.
REQ-028 3-bit pwm counter free-runs every clk, 7 wraps to 0; fan_pwm = fan && (pwm_cnt < duty).

Reset
REQ-029 rst SHALL force state IDLE, fan 0, fan_pwm 0, duty 0, fan_angle 0, stall 0, all counters 0, overriding tick in the same cycle.
REQ-030 Reset mid-SWEEP SHALL discard angle; operation restarts through SPINUP.

Configuration
REQ-031 Macro FAN_STALL_DETECT_EN SHALL enable stall detection: in RUN/SWEEP/HOLD, STALL_TICKS ticks without a tach rising edge -> STALL, stall=1, held until rst; tach counter clears on each rising edge and on state entry.
REQ-032 Without FAN_STALL_DETECT_EN, tach SHALL be ignored, stall tied 0, STALL unreachable; ports unchanged.

Verification
REQ-033 rst=1 with tick=1, calorie=7, temperature=7 -> next cycle state=0, fan=0, duty=0, fan_angle=0.
REQ-034 calorie=2, temperature=2, pressure=1, 5 ticks -> SPINUP after tick 1, duty=7, RUN after tick 5, duty=3.
REQ-035 In RUN, pressure=0, air_pressure=1, 12 ticks -> SWEEP, fan_angle 1,2,3,4,5,0 on every 2nd tick; air_pressure=0 -> HOLD, angle frozen.
REQ-036 In RUN, calorie=0 for 8 ticks -> COOLDOWN, duty=2, then IDLE, fan=0; calorie=2 at 4th tick -> RUN, counter reset.
REQ-037 duty=5, observe 16 clk -> fan_pwm high exactly 5 of each 8 cycles.
REQ-038 With FAN_STALL_DETECT_EN, RUN with tach=0 for 6 ticks -> state=6, stall=1, fan=0; tach pulse every 3 ticks -> no stall.
